ssd_display_driver: RTL
=======================

Name: ssd_display_driver

Overview:
- Downstream consumer of the CPU top's 13-bit debug SSD value: converts it to four BCD digits and time-multiplexes a 4-digit common-anode seven-segment display.
- Binary-to-BCD uses a sequential double-dabble engine, one shift iteration per clock, in parallel with the scan.
- Instantiated at board top between the CPU's SSD output and the FPGA anode/segment pins.

Parameters:
- REFRESH_BITS, 16, width of the free-running refresh counter; each digit is shown for 2^REFRESH_BITS clk cycles.
- BLANK_LEADING, 1, when 1, leading-zero digits 3..1 are blanked; digit 0 is never blanked.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- value  input  13  binary value to display, 0..8191.
- anode  output  4  active-low digit enables, one-hot-low; bit i = digit i (digit 0 = units).
- segments  output  7  active-low segments, bit order {a,b,c,d,e,f,g} = segments[6:0].
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, src_q=0, digits_q=0000 (BCD), refresh counter=0, digit index=0, shift/iteration registers=0. Outputs: anode=1110, segments=0000001 ('0'), busy=0. Reset mid-conversion aborts it; no partial result is committed.
- Converter FSM, two states:
  - IDLE: each edge compare value with src_q. If different, load src_q<=value and the shift register (value in the low 13 bits, 16-bit BCD field zeroed), set iteration count=0, go to CONV. Otherwise stay.
  - CONV: each edge, add 3 to every BCD nibble >=5, then shift the combined register left by 1. After the 13th iteration (count==12), write the resulting BCD into digits_q on that same edge and return to IDLE.
  - busy=1 exactly while in CONV.
- Latency: load at edge k; digits_q updated at edge k+13; display reflects the new value from k+13 onward.
- value changes during CONV are ignored until IDLE. On the first IDLE edge the mismatch is detected and a new conversion loads, so busy is low for exactly one cycle between back-to-back conversions.
- After reset release with value=0, no conversion starts. With value≠0, the conversion loads at the first edge with rst=1.
- Refresh counter: free-running REFRESH_BITS wide, wraps to 0. Digit index (2 bits) increments on the edge where the counter equals all-ones, wrapping 3→0. Scan continues during CONV and shows the old digits_q.
- Output decode is combinational from registered digit index and digits_q only:
  - anode = ~(1<<index).
  - segments = encoding of digits_q[index].
- Encodings (active-low abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any nibble >9 gives 1111111. This cannot occur in correct operation.
- Blanking (BLANK_LEADING=1): digit 3 is blank if it is 0. Digit 2 is blank if digits 3..2 are 0. Digit 1 is blank if digits 3..1 are 0. A blanked digit drives anode=1111 and segments=1111111 for its whole window. With BLANK_LEADING=0, all digits always display.

Test Plan:
- Reset with value=1234: after 3 cycles of rst=0, anode=1110, segments=0000001, busy=0. Release rst: busy=1 at next edge and stays 1 for 13 cycles. digits_q reads 1,2,3,4 (digit3..0). With REFRESH_BITS=2, digit-0 window shows 1001100 ('4').
- REFRESH_BITS=2, value=8191 converted: anode cycles 1110,1101,1011,0111, 4 cycles each, wraps. Segments are 1001111 ('1'), 0000100 ('9'), 1001111 ('1'), 0000000 ('8') in the matching windows.
- Blanking with value=7: digit-0 window gives 1110/0001111. Windows 1..3 give anode=1111, segments=1111111. Then value=0: digit 0 shows 0000001, others blank. Repeat with BLANK_LEADING=0 for value=7: digit windows 1..3 show 0000001.
- Change during conversion: value 100, then 250 applied 5 cycles after load. digits_q=0100 at load+13, busy low 1 cycle, second conversion loads, digits_q=0250 13 cycles later.
- Reset mid-conversion: value=4321, assert rst at iteration 7. Outputs return to reset values, digits_q=0000. After release, the conversion restarts and yields 4,3,2,1 after 13 cycles.
- Stable value: hold value=42 after conversion for 100 cycles. busy stays 0 and digits_q stays unchanged.

Source files
------------

// File: rtl/ssd_display_driver.sv
// Four-digit common-anode seven-segment driver for a 13-bit binary value.
// A sequential double-dabble engine converts to BCD while the refresh scan runs independently.
module ssd_display_driver #(
    parameter int REFRESH_BITS  = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        busy
);

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t                  state_r, state_s;
    logic [12:0]             src_r, src_s;
    logic [15:0]             digits_r, digits_s;
    logic [28:0]             shift_r, shift_s, dabbled_s;
    logic [3:0]              iter_r, iter_s;
    logic [REFRESH_BITS-1:0] refresh_r;
    logic [1:0]              idx_r;
    logic [3:0]              cur_digit_s;
    logic                    blank_s;

    // One double-dabble iteration: BCD field is [28:13], binary field is [12:0].
    function automatic logic [28:0] dabble(input logic [28:0] sr);
        logic [28:0] res;
        res = sr;
        for (int i = 0; i < 4; i++) begin
            res[13 + 4*i +: 4] = (res[13 + 4*i +: 4] >= 4'd5) ?
                                 res[13 + 4*i +: 4] + 4'd3 : res[13 + 4*i +: 4];
        end
        return {res[27:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Converter state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            src_r    <= 13'd0;
            digits_r <= 16'd0;
            shift_r  <= 29'd0;
            iter_r   <= 4'd0;
        end else begin
            state_r  <= state_s;
            src_r    <= src_s;
            digits_r <= digits_s;
            shift_r  <= shift_s;
            iter_r   <= iter_s;
        end
    end

    // Converter next-state: load on a value change, commit BCD on the 13th shift.
    always_comb begin
        state_s   = state_r;
        src_s     = src_r;
        digits_s  = digits_r;
        shift_s   = shift_r;
        iter_s    = iter_r;
        dabbled_s = dabble(shift_r);
        case (state_r)
            IDLE: begin
                if (value != src_r) begin
                    state_s = CONV;
                    src_s   = value;
                    shift_s = {16'd0, value};
                    iter_s  = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                shift_s = dabbled_s;
                if (iter_r == 4'd12) begin
                    digits_s = dabbled_s[28:13];
                    state_s  = IDLE;
                end else begin
                    iter_s = iter_r + 4'd1;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Free-running refresh counter; the digit index advances when it wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_r <= {REFRESH_BITS{1'b0}};
            idx_r     <= 2'd0;
        end else begin
            refresh_r <= refresh_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            if (&refresh_r) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign busy = (state_r == CONV);

    // Digit select and leading-zero blanking from the registered index and digits.
    always_comb begin
        cur_digit_s = digits_r[{idx_r, 2'b00} +: 4];
        blank_s     = 1'b0;
        if (BLANK_LEADING) begin
            case (idx_r)
                2'd3:    blank_s = (digits_r[15:12] == 4'd0);
                2'd2:    blank_s = (digits_r[15:8]  == 8'd0);
                2'd1:    blank_s = (digits_r[15:4]  == 12'd0);
                default: blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
        if (blank_s) begin
            anode    = 4'b1111;
            segments = 7'b1111111;
        end else begin
            anode    = ~(4'b0001 << idx_r);
            segments = seg_encode(cur_digit_s);
        end
    end

endmodule
